mpnb: RTL and testbench

MPNB -- requirements
Module: mpnb

---
 rtl/mpnb.sv | 184 ++++++++++++++++++
 tb/tb_mpnb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mpnb.sv
// mpnb: minimal accumulator processor with a single read-only memory port.
//
// Each instruction is one word. The opcode is the low nibble. Operand-bearing
// instructions (1-6, 8-A) fetch a second word from the next address.
//
// Ports:
//   clk       single clock; all state changes happen on the rising edge
//   rst       synchronous active-high reset
//   mem_req   read request, raised only in the two fetch states
//   mem_addr  read address (the program counter)
//   mem_ack   read data valid this cycle; ignored unless mem_req is 1
//   mem_data  read data
//   acc_o     accumulator
//   pc_o      program counter
//   flag_z    zero flag
//   flag_c    carry/borrow flag
//   state_o   FSM state
//   halt_o    1 while halted
//
// state   | meaning
// --------+---------------------------------------------------------------
// FETCH_I | read the instruction word at PC, then PC+1
// FETCH_D | read the operand word at PC, then PC+1
// EXEC    | compute the ALU result and the next flags into ACT
// WB      | commit ACT/flags or take a branch; a HLT goes to HALT
// HALT    | all registers frozen until rst
module mpnb #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] acc_o,
  output logic [AW-1:0] pc_o,
  output logic          flag_z,
  output logic          flag_c,
  output logic [2:0]    state_o,
  output logic          halt_o
);

  localparam logic [2:0] FETCH_I = 3'd0;
  localparam logic [2:0] FETCH_D = 3'd1;
  localparam logic [2:0] EXEC    = 3'd2;
  localparam logic [2:0] WB      = 3'd3;
  localparam logic [2:0] HALT    = 3'd4;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_JC  = 4'hA;
  localparam logic [3:0] OP_SHL = 4'hB;
  localparam logic [3:0] OP_SHR = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [AW-1:0] PC_ONE = AW'(1);

  logic [2:0]    state;
  logic [DW-1:0] acc;
  logic [DW-1:0] rd;
  logic [DW-1:0] act;
  logic [AW-1:0] pc;
  logic          z;
  logic          c;
  logic          act_z;
  logic          act_c;
  // Only the opcode nibble of the instruction word is ever decoded, so only
  // that part of RI is kept.
  logic [3:0]    ri;

  logic [DW-1:0] alu_res;
  logic          alu_c;
  logic          alu_z;
  logic [DW:0]   add_sum;
  logic [AW-1:0] rd_addr;
  logic          writes_acc;
  logic          take_jump;

  function automatic logic has_operand(input logic [3:0] op);
    return ((op >= OP_LDA) && (op <= OP_XOR)) || ((op >= OP_JMP) && (op <= OP_JC));
  endfunction

  // Jump target: low AW bits of the operand, zero-extended when AW > DW.
  generate
    if (AW <= DW) begin : g_addr_trunc
      assign rd_addr = rd[AW-1:0];
    end else begin : g_addr_ext
      assign rd_addr = {{(AW-DW){1'b0}}, rd};
    end
  endgenerate

  always_comb begin
    alu_res = acc;
    alu_c   = c;
    add_sum = {1'b0, acc} + {1'b0, rd};
    case (ri)
      OP_LDA: begin alu_res = rd;          alu_c = 1'b0;       end
      OP_ADD: begin alu_res = add_sum[DW-1:0]; alu_c = add_sum[DW]; end
      OP_SUB: begin alu_res = acc - rd;    alu_c = (acc < rd); end
      OP_AND: begin alu_res = acc & rd;    alu_c = 1'b0;       end
      OP_OR:  begin alu_res = acc | rd;    alu_c = 1'b0;       end
      OP_XOR: begin alu_res = acc ^ rd;    alu_c = 1'b0;       end
      OP_NOT: begin alu_res = ~acc;        alu_c = 1'b0;       end
      OP_SHL: begin {alu_c, alu_res} = {acc, 1'b0};            end
      OP_SHR: begin alu_res = {1'b0, acc[DW-1:1]}; alu_c = acc[0]; end
      default: begin alu_res = acc;        alu_c = c;          end
    endcase
    alu_z = (alu_res == '0);
  end

  always_comb begin
    writes_acc = ((ri >= OP_LDA) && (ri <= OP_NOT)) || (ri == OP_SHL) || (ri == OP_SHR);
    take_jump  = (ri == OP_JMP) || ((ri == OP_JZ) && z) || ((ri == OP_JC) && c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH_I;
      acc   <= '0;
      ri    <= '0;
      rd    <= '0;
      act   <= '0;
      pc    <= '0;
      z     <= 1'b0;
      c     <= 1'b0;
      act_z <= 1'b0;
      act_c <= 1'b0;
    end else begin
      case (state)
        FETCH_I: begin
          if (mem_ack) begin
            ri    <= mem_data[3:0];
            pc    <= pc + PC_ONE;
            state <= has_operand(mem_data[3:0]) ? FETCH_D : EXEC;
          end
        end
        FETCH_D: begin
          if (mem_ack) begin
            rd    <= mem_data;
            pc    <= pc + PC_ONE;
            state <= EXEC;
          end
        end
        EXEC: begin
          act   <= alu_res;
          act_z <= alu_z;
          act_c <= alu_c;
          state <= WB;
        end
        WB: begin
          if (writes_acc) begin
            acc <= act;
            z   <= act_z;
            c   <= act_c;
          end
          if (take_jump) pc <= rd_addr;
          state <= (ri == OP_HLT) ? HALT : FETCH_I;
        end
        HALT: state <= HALT;
        default: state <= FETCH_I;
      endcase
    end
  end

  // rst gates the request combinationally so no read is issued during reset.
  assign mem_req  = !rst && ((state == FETCH_I) || (state == FETCH_D));
  assign mem_addr = pc;
  assign acc_o    = acc;
  assign pc_o     = pc;
  assign flag_z   = z;
  assign flag_c   = c;
  assign state_o  = state;
  assign halt_o   = (state == HALT);

endmodule

// File: tb/tb_mpnb.sv
module tb_mpnb;
  logic       clk = 1'b0;
  logic       rst;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_data;
  logic [7:0] acc_o;
  logic [7:0] pc_o;
  logic       flag_z;
  logic       flag_c;
  logic [2:0] state_o;
  logic       halt_o;

  mpnb #(.DW(8), .AW(8)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .acc_o(acc_o), .pc_o(pc_o),
    .flag_z(flag_z), .flag_c(flag_c), .state_o(state_o), .halt_o(halt_o)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerr = 0;

  logic [7:0] mem [256];

  // Instruction-level model: architectural state plus the position inside
  // the current instruction, derived from the cycle-count rule.
  logic [7:0] m_acc, m_pc, n_acc, n_pc;
  logic       m_z, m_c, n_z, n_c, m_halt, n_halt;
  int         ph, ilen, nf, w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic decode();
    logic [3:0] op;
    logic [7:0] pa, opd;
    logic [8:0] s;
    bit opb;
    op  = mem[m_pc][3:0];
    pa  = m_pc + 8'd1;
    opd = mem[pa];
    opb = ((op >= 1) && (op <= 6)) || ((op >= 8) && (op <= 10));
    nf  = opb ? 2 : 1;
    ilen = nf * (w + 1) + 2;
    n_acc = m_acc; n_z = m_z; n_c = m_c; n_halt = 1'b0;
    n_pc = m_pc + (opb ? 8'd2 : 8'd1);
    case (op)
      4'h1: begin n_acc = opd; n_c = 1'b0; end
      4'h2: begin s = {1'b0, m_acc} + {1'b0, opd}; n_acc = s[7:0]; n_c = s[8]; end
      4'h3: begin n_acc = m_acc - opd; n_c = (m_acc < opd); end
      4'h4: begin n_acc = m_acc & opd; n_c = 1'b0; end
      4'h5: begin n_acc = m_acc | opd; n_c = 1'b0; end
      4'h6: begin n_acc = m_acc ^ opd; n_c = 1'b0; end
      4'h7: begin n_acc = ~m_acc; n_c = 1'b0; end
      4'h8: n_pc = opd;
      4'h9: if (m_z) n_pc = opd;
      4'hA: if (m_c) n_pc = opd;
      4'hB: begin n_c = m_acc[7]; n_acc = m_acc << 1; end
      4'hC: begin n_c = m_acc[0]; n_acc = m_acc >> 1; end
      4'hF: n_halt = 1'b1;
      default: ;
    endcase
    if (((op >= 1) && (op <= 7)) || (op == 4'hB) || (op == 4'hC)) n_z = (n_acc == 8'h00);
  endtask

  // Runs n cycles starting at a falling edge: drives memory responses and
  // checks every cycle against the model.
  task automatic run(input int n);
    logic [7:0] a;
    logic [2:0] exp_st;
    bit inf;
    int fi;
    for (int k = 0; k < n; k++) begin
      if (m_halt) begin
        mem_ack = 1'b1; mem_data = 8'h3C;
        #1;
        check("halt_state", state_o, 3'd4);
        check("halt_o", halt_o, 1'b1);
        check("halt_req", mem_req, 1'b0);
        check("halt_pc", pc_o, m_pc);
        check("halt_acc", acc_o, m_acc);
      end else begin
        if (ph == 0) decode();
        inf = (ph < nf * (w + 1));
        fi  = ph / (w + 1);
        a   = m_pc + 8'(fi);
        if (inf) begin
          mem_ack  = ((ph % (w + 1)) == w);
          mem_data = mem_ack ? mem[a] : 8'h5A;
        end else begin
          mem_ack  = 1'b1;       // spurious ack while no request is out
          mem_data = 8'hC3;
        end
        #1;
        exp_st = inf ? ((fi == 0) ? 3'd0 : 3'd1) : ((ph == ilen - 2) ? 3'd2 : 3'd3);
        check("state", state_o, exp_st);
        check("mem_req", mem_req, inf);
        if (inf) check("mem_addr", mem_addr, a);
        check("halt_low", halt_o, 1'b0);
        if (ph == 0) begin
          check("acc", acc_o, m_acc);
          check("pc", pc_o, m_pc);
          check("z", flag_z, m_z);
          check("c", flag_c, m_c);
        end
        ph++;
        if (ph == ilen) begin
          m_acc = n_acc; m_pc = n_pc; m_z = n_z; m_c = n_c; m_halt = n_halt;
          ph = 0;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input int n, input logic ackv);
    for (int i = 0; i < n; i++) begin
      rst = 1'b1; mem_ack = ackv; mem_data = 8'hAA;
      #1;
      check("req_in_rst", mem_req, 1'b0);
      @(negedge clk);
      check("rst_acc", acc_o, 8'h00);
      check("rst_pc", pc_o, 8'h00);
      check("rst_state", state_o, 3'd0);
      check("rst_halt", halt_o, 1'b0);
      check("rst_z", flag_z, 1'b0);
      check("rst_c", flag_c, 1'b0);
    end
    rst = 1'b0; mem_ack = 1'b0;
    m_acc = 8'h00; m_pc = 8'h00; m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0; ph = 0;
  endtask

  task automatic load_a();
    clear_mem();
    mem[0] = 8'h01; mem[1] = 8'h0F; mem[2] = 8'h02; mem[3] = 8'hF1; mem[4] = 8'h0F;
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_data = 8'h00; w = 0;
    load_a();
    do_reset(2, 1'b0);

    // LDA 0F; ADD F1 -> 00 with carry
    run(8);
    check("a_acc", acc_o, 8'h00);
    check("a_z", flag_z, 1'b1);
    check("a_c", flag_c, 1'b1);
    check("a_pc", pc_o, 8'h04);
    run(13);
    check("a_halted", halt_o, 1'b1);
    check("a_halt_pc", pc_o, 8'h05);
    do_reset(1, 1'b1);

    // reset for 2 cycles in the middle of EXEC
    run(2);
    do_reset(2, 1'b0);
    #1;
    check("post_rst_req", mem_req, 1'b1);
    check("post_rst_addr", mem_addr, 8'h00);
    // reset while an operand fetch is being acknowledged
    run(5);
    do_reset(1, 1'b1);
    run(8);
    check("abort_acc", acc_o, 8'h00);
    check("abort_c", flag_c, 1'b1);

    // same program with three wait states per fetch
    w = 3;
    do_reset(1, 1'b0);
    run(20);
    check("w_acc", acc_o, 8'h00);
    check("w_z", flag_z, 1'b1);
    check("w_c", flag_c, 1'b1);
    check("w_pc", pc_o, 8'h04);
    w = 0;

    // conditional jumps and subtract with borrow
    clear_mem();
    mem[8'h00] = 8'h01; mem[8'h01] = 8'h00;
    mem[8'h02] = 8'h09; mem[8'h03] = 8'h20;
    mem[8'h20] = 8'h01; mem[8'h21] = 8'h01;
    mem[8'h22] = 8'h08; mem[8'h23] = 8'h10;
    mem[8'h10] = 8'h09; mem[8'h11] = 8'h20;
    mem[8'h12] = 8'h01; mem[8'h13] = 8'h05;
    mem[8'h14] = 8'h03; mem[8'h15] = 8'h06;
    mem[8'h16] = 8'h0F;
    do_reset(1, 1'b0);
    run(8);
    check("jz_taken_pc", pc_o, 8'h20);
    run(12);
    check("jz_not_taken_pc", pc_o, 8'h12);
    run(8);
    check("sub_acc", acc_o, 8'hFF);
    check("sub_c", flag_c, 1'b1);
    run(13);

    // PC wrap: LDA at FF takes its operand from 00
    clear_mem();
    mem[8'h00] = 8'h05; mem[8'h01] = 8'h00;
    mem[8'h02] = 8'h08; mem[8'h03] = 8'hFF;
    mem[8'hFF] = 8'h01;
    do_reset(1, 1'b0);
    run(12);
    check("wrap_acc", acc_o, 8'h05);
    check("wrap_pc", pc_o, 8'h01);

    // remaining ops, JC, ignored opcode D, HLT with upper bits set, one wait state
    clear_mem();
    mem[8'h00] = 8'h01; mem[8'h01] = 8'h81; mem[8'h02] = 8'h0B;
    mem[8'h03] = 8'h0A; mem[8'h04] = 8'h08; mem[8'h05] = 8'h0F;
    mem[8'h08] = 8'h0C; mem[8'h09] = 8'h05; mem[8'h0A] = 8'hF0;
    mem[8'h0B] = 8'h04; mem[8'h0C] = 8'h3C; mem[8'h0D] = 8'h06;
    mem[8'h0E] = 8'h30; mem[8'h0F] = 8'h07; mem[8'h10] = 8'h00;
    mem[8'h11] = 8'h0D; mem[8'h12] = 8'h02; mem[8'h13] = 8'h01;
    mem[8'h14] = 8'h0A; mem[8'h15] = 8'h18; mem[8'h16] = 8'h0F;
    mem[8'h18] = 8'h03; mem[8'h19] = 8'h01; mem[8'h1A] = 8'h5F;
    w = 1;
    do_reset(1, 1'b0);
    run(200);
    check("mix_acc", acc_o, 8'hFF);
    check("mix_c", flag_c, 1'b1);
    check("mix_z", flag_z, 1'b0);
    check("mix_halt", halt_o, 1'b1);
    check("mix_pc", pc_o, 8'h1B);
    do_reset(1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
